// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, default widths and the rounding shift for SDF FFT stages
package fft_pkg;
  localparam int DW_DEF = 22;
  localparam int TW_DEF = 8;
  localparam int TFRAC_DEF = 6;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_BFLY, S_TWID, S_DRAIN} state_e;
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh, input bit rnd);
    logic signed [63:0] bias;
    bias = (rnd && sh > 0) ? 64'sd1 <<< (sh - 1) : 64'sd0;
    return (v + bias) >>> sh;
  endfunction
endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: DEPTH-entry shift register with enable, oldest entry on head_o
module sdf_delay_line #(
  parameter int DEPTH = 16,
  parameter int W = 46
) (
  input  logic         clk,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] head_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  assign head_o = mem_q[DEPTH-1];
endmodule

// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage: radix-2 single-path delay-feedback FFT stage with external twiddle ROM
module sdf_r2_stage import fft_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int TFRAC = TFRAC_DEF,
  parameter int DEPTH = 16,
  parameter int ROUND = 1,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int PW = $clog2(2 * DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 inv,
  input  logic signed [DW-1:0] data_in_real,
  input  logic signed [DW-1:0] data_in_imag,
  input  logic signed [TW-1:0] wnr_in_real,
  input  logic signed [TW-1:0] wnr_in_imag,
  output logic                 in_ready,
  output logic [AW-1:0]        tw_addr,
  output logic                 out_valid,
  output logic signed [DW:0]   data_out_real,
  output logic signed [DW:0]   data_out_imag
);
  localparam int EW = DW + 1;
  state_e state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_n;
  logic inv_q, acc, step, emit;
  logic signed [EW-1:0] in_r, in_i, hd_r, hd_i, sum_r, sum_i, dif_r, dif_i, tw_r, tw_i;
  logic [2*EW-1:0] dl_in, dl_head;
  logic signed [63:0] wr, wi, prod_r, prod_i;

  assign in_ready = state_q != S_DRAIN;
  assign acc = in_valid && in_ready;
  assign step = acc || state_q == S_DRAIN;
  assign emit = state_q inside {S_BFLY, S_TWID, S_DRAIN};
  assign tw_addr = AW'(pos_q);
  assign pos_n = pos_q + PW'(1);

  assign in_r = EW'(data_in_real);
  assign in_i = EW'(data_in_imag);
  assign hd_r = dl_head[2*EW-1:EW];
  assign hd_i = dl_head[EW-1:0];
  assign sum_r = hd_r + in_r;
  assign sum_i = hd_i + in_i;
  assign dif_r = hd_r - in_r;
  assign dif_i = hd_i - in_i;

  // inverse transform uses the conjugate twiddle, fixed for the whole frame
  assign wr = 64'(wnr_in_real);
  assign wi = inv_q ? -64'(wnr_in_imag) : 64'(wnr_in_imag);
  assign prod_r = 64'(hd_r) * wr - 64'(hd_i) * wi;
  assign prod_i = 64'(hd_i) * wr + 64'(hd_r) * wi;
  assign tw_r = EW'(round_shift(prod_r, TFRAC, ROUND != 0));
  assign tw_i = EW'(round_shift(prod_i, TFRAC, ROUND != 0));

  assign dl_in = state_q == S_BFLY ? {dif_r, dif_i} : state_q == S_DRAIN ? '0 : {in_r, in_i};

  sdf_delay_line #(.DEPTH(DEPTH), .W(2 * EW)) u_dl (
    .clk    (clk),
    .en_i   (step),
    .d_i    (dl_in),
    .head_o (dl_head)
  );

  always_comb begin
    state_d = state_q == S_BFLY ? (acc && in_last && pos_q == '1 ? S_DRAIN : pos_n == '0 ? S_TWID : S_BFLY)
            : state_q == S_DRAIN ? (pos_n == PW'(DEPTH) ? S_IDLE : S_DRAIN)
            : pos_n == PW'(DEPTH) ? S_BFLY : state_q == S_TWID ? S_TWID : S_FILL;
    pos_d = state_d == S_IDLE ? '0 : pos_n;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q <= '0;
      inv_q <= 1'b0;
      out_valid <= 1'b0;
      data_out_real <= '0;
      data_out_imag <= '0;
    end else begin
      if (state_q == S_IDLE) inv_q <= inv;
      out_valid <= step && emit;
      if (step) begin
        state_q <= state_d;
        pos_q <= pos_d;
      end
      if (step && emit) begin
        data_out_real <= state_q == S_BFLY ? sum_r : tw_r;
        data_out_imag <= state_q == S_BFLY ? sum_i : tw_i;
      end
    end
endmodule
